// File: rtl/fwd_ctl_pkg.sv
// Shared pipeline types for the forwarding/hazard controller and the EX stage
// that consumes its forwarding selects.
package fwd_ctl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    FWD_NONE       = 2'd0,
    FWD_FROM_EXMEM = 2'd1,
    FWD_FROM_MEMWB = 2'd2
  } fwd_t;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             destValid;
    logic             load;
  } entry_t;

  localparam entry_t BUBBLE_ENTRY = '{dest: REG_ZERO, destValid: 1'b0, load: 1'b0};

  // r0 is hardwired, so a write to it never produces a forwardable value
  function automatic logic isLive(input entry_t e);
    return e.destValid && (e.dest != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_ctl_match.sv
// Priority compare of one ID source register against the EX and EX/MEM
// shadow entries; also flags a load-use hit against the EX entry.
module fwd_match
  import fwd_ctl_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_srcValid,
  input  entry_t           i_ex,
  input  entry_t           i_exMem,
  output fwd_t             o_fwd,
  output logic             o_loadHit
);

  logic w_srcUsed;
  logic w_exHit;
  logic w_exMemHit;

  assign w_srcUsed  = i_srcValid && (i_src != REG_ZERO);
  assign w_exHit    = w_srcUsed && isLive(i_ex) && (i_ex.dest == i_src);
  assign w_exMemHit = w_srcUsed && isLive(i_exMem) && (i_exMem.dest == i_src);
  assign o_loadHit  = w_exHit && i_ex.load;

  // The youngest producer wins; load data returns on the EX/MEM path, so a
  // load sitting in EX/MEM (after its stall cycle) also selects FWD_FROM_EXMEM.
  always_comb begin
    o_fwd = FWD_NONE;
    if (w_exHit) begin
      o_fwd = FWD_FROM_EXMEM;
    end else if (w_exMemHit) begin
      o_fwd = i_exMem.load ? FWD_FROM_EXMEM : FWD_FROM_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_ctl.sv
// Forwarding and load-use hazard controller tracking the EX, EX/MEM and
// MEM/WB destinations of a 5-stage pipeline.
module fwd_ctl
  import fwd_ctl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] A_reg,
  input  logic             A_reg_valid,
  input  logic [REG_W-1:0] B_reg,
  input  logic             B_reg_valid,
  input  logic [REG_W-1:0] id_dest_reg,
  input  logic             id_dest_reg_valid,
  input  logic             id_load_inst,
  input  logic             hold,
  input  logic             flush,
  output fwd_t             A_fwd_from,
  output fwd_t             B_fwd_from,
  output logic             ex_bubble,
  output logic             id_stall,
  output logic [15:0]      stall_count
);

  entry_t      r_ex;
  entry_t      r_exMem;
  entry_t      r_memWb;
  fwd_t        r_aFwd;
  fwd_t        r_bFwd;
  logic        r_exBubble;
  logic [15:0] r_stallCount;

  fwd_t   w_aFwd;
  fwd_t   w_bFwd;
  logic   w_aLoadHit;
  logic   w_bLoadHit;
  logic   w_loadUse;
  logic   w_bubble;
  entry_t w_idEntry;

  fwd_match u_matchA (
    .i_src      (A_reg),
    .i_srcValid (A_reg_valid),
    .i_ex       (r_ex),
    .i_exMem    (r_exMem),
    .o_fwd      (w_aFwd),
    .o_loadHit  (w_aLoadHit)
  );

  fwd_match u_matchB (
    .i_src      (B_reg),
    .i_srcValid (B_reg_valid),
    .i_ex       (r_ex),
    .i_exMem    (r_exMem),
    .o_fwd      (w_bFwd),
    .o_loadHit  (w_bLoadHit)
  );

  assign w_loadUse = !hold && !flush && id_valid && (w_aLoadHit || w_bLoadHit);
  assign w_bubble  = w_loadUse || flush || !id_valid;
  assign w_idEntry = '{dest: id_dest_reg, destValid: id_dest_reg_valid, load: id_load_inst};

  // A held pipeline cannot accept ID either, so hold alone raises the stall
  assign id_stall = !reset && (hold || w_loadUse);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex         <= BUBBLE_ENTRY;
      r_exMem      <= BUBBLE_ENTRY;
      r_memWb      <= BUBBLE_ENTRY;
      r_aFwd       <= FWD_NONE;
      r_bFwd       <= FWD_NONE;
      r_exBubble   <= 1'b1;
      r_stallCount <= 16'd0;
    end else if (!hold) begin
      r_memWb <= r_exMem;
      r_exMem <= r_ex;
      if (w_bubble) begin
        r_ex       <= BUBBLE_ENTRY;
        r_aFwd     <= FWD_NONE;
        r_bFwd     <= FWD_NONE;
        r_exBubble <= 1'b1;
      end else begin
        r_ex       <= w_idEntry;
        r_aFwd     <= w_aFwd;
        r_bFwd     <= w_bFwd;
        r_exBubble <= 1'b0;
      end
      if (w_loadUse && (r_stallCount != STALL_COUNT_MAX)) begin
        r_stallCount <= r_stallCount + 16'd1;
      end
    end
  end

  assign A_fwd_from  = r_aFwd;
  assign B_fwd_from  = r_bFwd;
  assign ex_bubble   = r_exBubble;
  assign stall_count = r_stallCount;

endmodule

// File: doc/fwd_ctl.md
FWD_CTL -- requirements
Module: fwd_ctl

Interface
REQ-001 SHALL have no parameters; register index width fixed at 5, tracked pipeline depth fixed at 3 (EX, EX/MEM, MEM/WB).
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  ID holds a real instruction.
REQ-005 A_reg, B_reg  in  5 each  ID source registers; A_reg_valid, B_reg_valid  in  1 each  qualify them.
REQ-006 id_dest_reg  in  5; id_dest_reg_valid  in  1; id_load_inst  in  1  ID destination and load flag.
REQ-007 hold  in  1  downstream memory stall; freezes all tracking.
REQ-008 flush  in  1  branch redirect; kills the ID instruction.
REQ-009 A_fwd_from, B_fwd_from  out  fwd_t  registered forwarding selects presented with the instruction now in EX.
REQ-010 ex_bubble  out  1  registered; EX holds an inserted NOP.
REQ-011 id_stall  out  1  combinational; ID/IF SHALL not advance.
REQ-012 stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-013 SHALL keep shadow entries {dest, dest_valid, load} for EX, EX/MEM and MEM/WB; an entry is live only if dest_valid=1 and dest!=0.
REQ-014 Advance (hold=0): MEM/WB<=EX/MEM, EX/MEM<=EX, EX<=ID entry, or a bubble entry (dest_valid=0) when id_stall=1, flush=1 or id_valid=0.
REQ-015 hold=1 SHALL freeze all entries, both fwd selects, ex_bubble and stall_count; id_stall SHALL be 1.
REQ-016 Load-use: id_stall=1 when hold=0, flush=0, id_valid=1, EX entry live with load=1, and its dest equals a valid ID source.
REQ-017 Select for each valid source S, computed in ID and registered on advance: FWD_FROM_EXMEM if the EX entry is live and dest==S; else FWD_FROM_MEMWB if the EX/MEM entry is live and dest==S; else FWD_NONE.
REQ-018 Youngest producer SHALL win when EX and EX/MEM both match.
REQ-019 Source with valid=0 or index 0 SHALL give FWD_NONE.
REQ-020 On bubble insertion both selects SHALL be FWD_NONE and ex_bubble=1; latency from ID to select is exactly one cycle.
REQ-021 Load-use stall SHALL last exactly one cycle per hazard; the re-presented instruction then takes FWD_FROM_EXMEM from the load, now in EX/MEM.
REQ-022 flush=1 SHALL override id_stall (id_stall=0) and insert a bubble.
REQ-023 Producers older than MEM/WB are not tracked; the register file's write-before-read covers them.
REQ-024 stall_count SHALL increment on each cycle with id_stall=1 and hold=0, and saturate at 16'hFFFF.

Reset
REQ-025 reset=1 SHALL invalidate all three entries and set A_fwd_from=B_fwd_from=FWD_NONE, ex_bubble=1 and stall_count=0.
REQ-026 While reset=1, id_stall SHALL be 0.
REQ-027 Reset SHALL take priority over hold and flush, including mid-stall.

Structure
REQ-028 fwd_t (FWD_NONE, FWD_FROM_EXMEM, FWD_FROM_MEMWB) SHALL be imported from the shared pipeline package, and is the same type the EX stage consumes.
REQ-029 The package SHALL also hold a REG_ZERO constant (5'd0).
REQ-030 One sub-module, fwd_match, SHALL perform the per-source priority compare and be instantiated twice (A and B).

Verification
REQ-031 addu r3 then addu r4,r3,r1 back-to-back -> second instruction's EX cycle shows A_fwd_from=FWD_FROM_EXMEM, no stall.
REQ-032 addu r3, nop, subu r5,r1,r3 -> B_fwd_from=FWD_FROM_MEMWB.
REQ-033 lw r2 then addu r6,r2,r2 -> id_stall=1 for one cycle, ex_bubble=1, then A and B selects=FWD_FROM_EXMEM, stall_count=1.
REQ-034 addu r7 twice, then read r7 -> FWD_FROM_EXMEM (youngest wins); a write to r0 followed by a read of r0 -> FWD_NONE.
REQ-035 lw r2 hazard with hold=1 for 3 cycles -> selects and stall_count frozen, stall resolves one advancing cycle after hold drops.
REQ-036 Assert reset during a load-use stall -> next cycle id_stall=0, selects FWD_NONE, stall_count=0; assert flush with a hazard present -> id_stall=0 and a bubble is inserted.
